// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversampling constants and
// the baud divider calculation used by both the RX and TX paths.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  localparam int OVERSAMPLE = 16;
  localparam int SAMPLE_LO  = 7;
  localparam int SAMPLE_HI  = 9;

  // Rounded clock cycles per oversample tick, never less than one.
  function automatic int calc_div(input longint clk_hz, input longint baud);
    longint d;
    d = (clk_hz + (baud * OVERSAMPLE) / 2) / (baud * OVERSAMPLE);
    if (d < 1) d = 1;
    return int'(d);
  endfunction

endpackage

// File: rtl/uart_rx_sfifo.sv
// uart_rx_sfifo: synchronous show-ahead FIFO. The head entry is presented
// combinationally on data_o while not empty and reads as zero when empty.
module uart_rx_sfifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       data_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_pop;
  logic             do_push;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside a pop.
  always_comb begin
    empty_o = (count_q == '0);
    full_o  = (count_q == DEPTH_C);
    do_pop  = pop_i && !empty_o;
    do_push = push_i && (!full_o || do_pop);
    count_o = count_q;
    data_o  = empty_o ? '0 : mem_q[rd_ptr_q];
  end

  // Storage array is write-only from the push side and needs no reset.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  // Pointers wrap naturally at DEPTH; occupancy holds when push and pop coincide.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_buffered.sv
// uart_rx_buffered: 16x oversampled 8N1 receiver with 3-sample majority vote,
// a show-ahead RX FIFO and sticky overflow / framing-error flags.
module uart_rx_buffered
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 38400,
  parameter int OVERSAMPLE = 16,
  parameter int DEPTH      = 16
) (
  input  logic                   sys_clk,
  input  logic                   sys_nrst,
  input  logic                   rx_en,
  input  logic                   rx_rd,
  output logic                   rx_valid,
  output logic [7:0]             rx_data,
  output logic [$clog2(DEPTH):0] rx_count,
  output logic                   rx_overflow,
  output logic                   rx_frame_err,
  input  logic                   err_clr,
  input  logic                   RX
);

  localparam int DIV = calc_div(CLK_HZ, BAUD);
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
  localparam logic [3:0] SC_LO   = 4'(SAMPLE_LO);
  localparam logic [3:0] SC_MID  = 4'(SAMPLE_LO + 1);
  localparam logic [3:0] SC_HI   = 4'(SAMPLE_HI);
  localparam logic [3:0] SC_LAST = 4'(uart_pkg::OVERSAMPLE - 1);

  if (OVERSAMPLE != uart_pkg::OVERSAMPLE) begin : g_os_check
    $error("uart_rx_buffered: OVERSAMPLE must be 16");
  end
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
    $error("uart_rx_buffered: DEPTH must be a power of 2 and at least 2");
  end

  rx_state_t     state_q, state_d;
  logic          rx_meta_q, line_q;
  logic [TW-1:0] tick_q;
  logic          tick;
  logic [3:0]    sc_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    shift_q;
  logic          samp_lo_q, samp_mid_q;
  logic          vote, at_hi, at_end;
  logic          start_det, shift_en, push_d, frame_set;
  logic          push_q;
  logic          fifo_full, fifo_empty;
  logic          ovf_set;
  logic          overflow_q, frame_err_q;

  // Two-flop synchroniser; idles high so reset never looks like a start bit.
  always_ff @(posedge sys_clk or negedge sys_nrst) begin
    if (!sys_nrst) begin
      rx_meta_q <= 1'b1;
      line_q    <= 1'b1;
    end else begin
      rx_meta_q <= RX;
      line_q    <= rx_meta_q;
    end
  end

  // Free-running oversample tick divider; deliberately not realigned to start edges.
  always_ff @(posedge sys_clk or negedge sys_nrst) begin
    if (!sys_nrst) tick_q <= '0;
    else if (tick) tick_q <= '0;
    else           tick_q <= tick_q + 1'b1;
  end

  // Bit-timing helpers: majority of samples 7, 8 and the live sample at 9.
  always_comb begin
    tick   = (tick_q == TICK_LAST);
    vote   = (samp_lo_q & samp_mid_q) | (samp_lo_q & line_q) | (samp_mid_q & line_q);
    at_hi  = tick && (sc_q == SC_HI);
    at_end = tick && (sc_q == SC_LAST);
  end

  // FSM state register.
  always_ff @(posedge sys_clk or negedge sys_nrst) begin
    if (!sys_nrst) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // FSM next state; dropping rx_en abandons any frame in progress.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (tick && !line_q && rx_en) state_d = START;
      START: begin
        if (!rx_en)              state_d = IDLE;
        else if (at_hi && vote)  state_d = IDLE;
        else if (at_end)         state_d = DATA;
      end
      DATA: begin
        if (!rx_en)                          state_d = IDLE;
        else if (at_end && bit_idx_q == 3'd7) state_d = STOP;
      end
      STOP: begin
        if (!rx_en)     state_d = IDLE;
        else if (at_hi) state_d = vote ? IDLE : BREAK;
      end
      BREAK: if (tick && line_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: start detection, data shifting and stop-bit verdicts.
  always_comb begin
    start_det = (state_q == IDLE) && tick && !line_q && rx_en;
    shift_en  = (state_q == DATA) && rx_en && at_hi;
    push_d    = (state_q == STOP) && rx_en && at_hi && vote;
    frame_set = (state_q == STOP) && rx_en && at_hi && !vote;
  end

  // Per-bit sample counter, vote samples, shift register and bit index.
  always_ff @(posedge sys_clk or negedge sys_nrst) begin
    if (!sys_nrst) begin
      sc_q       <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      samp_lo_q  <= 1'b1;
      samp_mid_q <= 1'b1;
    end else begin
      if (start_det) sc_q <= '0;
      else if (tick) sc_q <= sc_q + 4'd1;
      if (tick && sc_q == SC_LO)  samp_lo_q  <= line_q;
      if (tick && sc_q == SC_MID) samp_mid_q <= line_q;
      if (shift_en) shift_q <= {vote, shift_q[7:1]};
      if (state_q != DATA) bit_idx_q <= '0;
      else if (at_end)     bit_idx_q <= bit_idx_q + 3'd1;
    end
  end

  // The good byte is pushed one cycle after the stop-bit decision.
  always_ff @(posedge sys_clk or negedge sys_nrst) begin
    if (!sys_nrst) push_q <= 1'b0;
    else           push_q <= push_d;
  end

  uart_rx_sfifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (sys_clk),
    .rst_ni  (sys_nrst),
    .push_i  (push_q),
    .data_i  (shift_q),
    .pop_i   (rx_rd),
    .data_o  (rx_data),
    .count_o (rx_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // A byte is lost only when full and not being drained in the same cycle.
  always_comb begin
    ovf_set      = push_q && fifo_full && !(rx_rd && !fifo_empty);
    rx_valid     = !fifo_empty;
    rx_overflow  = overflow_q;
    rx_frame_err = frame_err_q;
  end

  // Sticky error flags; a new error outranks a simultaneous clear.
  always_ff @(posedge sys_clk or negedge sys_nrst) begin
    if (!sys_nrst) begin
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      if (ovf_set)      overflow_q <= 1'b1;
      else if (err_clr) overflow_q <= 1'b0;
      if (frame_set)    frame_err_q <= 1'b1;
      else if (err_clr) frame_err_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Self-checking bench for uart_rx_buffered: serial frames are driven bit by bit
// and the received stream is compared against a bounded-queue FIFO model.
module tb_uart_rx_buffered;
  import uart_pkg::*;

  localparam int BIT   = 160;
  localparam int DEPTH = 16;

  logic       sys_clk = 1'b0;
  logic       sys_nrst;
  logic       rx_en;
  logic       rx_rd;
  logic       err_clr;
  logic       RX;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic [4:0] rx_count;
  logic       rx_overflow;
  logic       rx_frame_err;

  int         testsRun;
  int         testsFailed;
  logic [7:0] modelQ[$];
  logic       modelOvf;

  uart_rx_buffered #(
    .CLK_HZ     (6_144_000),
    .BAUD       (38400),
    .OVERSAMPLE (16),
    .DEPTH      (DEPTH)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_nrst     (sys_nrst),
    .rx_en        (rx_en),
    .rx_rd        (rx_rd),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_count     (rx_count),
    .rx_overflow  (rx_overflow),
    .rx_frame_err (rx_frame_err),
    .err_clr      (err_clr),
    .RX           (RX)
  );

  always #5 sys_clk = ~sys_clk;

  // Hold the line at one level for n clock cycles, aligned to falling edges.
  task automatic driveBit(input logic v, input int n);
    RX = v;
    repeat (n) @(negedge sys_clk);
  endtask

  // Drive a complete 8N1 frame, LSB first, with a chosen stop level and bit length.
  task automatic sendFrame(input logic [7:0] b, input logic stopBit, input int bc);
    driveBit(1'b0, bc);
    for (int i = 0; i < 8; i++) driveBit(b[i], bc);
    driveBit(stopBit, bc);
    RX = 1'b1;
  endtask

  // Model of a good byte arriving: stored if room, otherwise lost with overflow.
  task automatic modelPush(input logic [7:0] b);
    if (modelQ.size() < DEPTH) modelQ.push_back(b);
    else modelOvf = 1'b1;
  endtask

  task automatic popOnce();
    rx_rd = 1'b1;
    @(negedge sys_clk);
    rx_rd = 1'b0;
  endtask

  task automatic test_reset();
    sys_nrst = 1'b0;
    repeat (4) @(negedge sys_clk);
    if (rx_valid !== 1'b0 || rx_data !== 8'h00 || rx_count !== 5'd0) begin
      testsFailed++;
      $display("[TB] FAIL reset_fifo: got valid=%b data=%h count=%0d, expected 0/00/0", rx_valid, rx_data, rx_count);
    end
    testsRun++;
    if (rx_overflow !== 1'b0 || rx_frame_err !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_flags: got ovf=%b ferr=%b, expected 0/0", rx_overflow, rx_frame_err);
    end
    testsRun++;
    if (dut.state_q !== IDLE) begin
      testsFailed++;
      $display("[TB] FAIL reset_state: got %0d, expected IDLE", dut.state_q);
    end
    testsRun++;
    sys_nrst = 1'b1;
    repeat (4) @(negedge sys_clk);
  endtask

  task automatic test_basic();
    logic [7:0] b;
    int firstK;
    b = 8'hA5;
    firstK = -1;
    driveBit(1'b0, BIT);
    for (int i = 0; i < 8; i++) driveBit(b[i], BIT);
    RX = 1'b1;
    for (int k = 1; k <= BIT; k++) begin
      @(negedge sys_clk);
      if (firstK < 0 && rx_valid === 1'b1) firstK = k;
    end
    if (firstK < 85 || firstK > 115) begin
      testsFailed++;
      $display("[TB] FAIL basic_latency: got valid after %0d cycles of stop bit, expected 85..115", firstK);
    end
    testsRun++;
    if (rx_data !== 8'hA5 || rx_count !== 5'd1) begin
      testsFailed++;
      $display("[TB] FAIL basic_byte: got data=%h count=%0d, expected a5/1", rx_data, rx_count);
    end
    testsRun++;
    popOnce();
    if (rx_valid !== 1'b0 || rx_data !== 8'h00 || rx_count !== 5'd0) begin
      testsFailed++;
      $display("[TB] FAIL basic_pop: got valid=%b data=%h count=%0d, expected 0/00/0", rx_valid, rx_data, rx_count);
    end
    testsRun++;
  endtask

  task automatic test_glitch_back_to_back();
    logic [7:0] expByte;
    driveBit(1'b0, 40);
    driveBit(1'b1, 200);
    if (rx_count !== 5'd0 || rx_frame_err !== 1'b0 || dut.state_q !== IDLE) begin
      testsFailed++;
      $display("[TB] FAIL glitch: got count=%0d ferr=%b state=%0d, expected 0/0/IDLE", rx_count, rx_frame_err, dut.state_q);
    end
    testsRun++;
    sendFrame(8'h00, 1'b1, BIT);  modelPush(8'h00);
    sendFrame(8'hFF, 1'b1, BIT);  modelPush(8'hFF);
    sendFrame(8'h5A, 1'b1, 155);  modelPush(8'h5A);
    driveBit(1'b1, 20);
    if (rx_count !== 5'd3) begin
      testsFailed++;
      $display("[TB] FAIL b2b_count: got %0d, expected 3", rx_count);
    end
    testsRun++;
    for (int i = 0; i < 3; i++) begin
      expByte = modelQ.pop_front();
      if (rx_valid !== 1'b1 || rx_data !== expByte) begin
        testsFailed++;
        $display("[TB] FAIL b2b_byte%0d: got valid=%b data=%h, expected 1/%h", i, rx_valid, rx_data, expByte);
      end
      testsRun++;
      popOnce();
    end
  endtask

  task automatic test_frame_err();
    sendFrame(8'h3C, 1'b0, BIT);
    driveBit(1'b0, 400);
    if (rx_count !== 5'd0 || rx_frame_err !== 1'b1 || dut.state_q !== BREAK) begin
      testsFailed++;
      $display("[TB] FAIL ferr_detect: got count=%0d ferr=%b state=%0d, expected 0/1/BREAK", rx_count, rx_frame_err, dut.state_q);
    end
    testsRun++;
    driveBit(1'b1, 200);
    sendFrame(8'h11, 1'b1, BIT);
    driveBit(1'b1, 20);
    if (rx_count !== 5'd1 || rx_data !== 8'h11 || rx_frame_err !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL ferr_recover: got count=%0d data=%h ferr=%b, expected 1/11/1", rx_count, rx_data, rx_frame_err);
    end
    testsRun++;
    popOnce();
    err_clr = 1'b1;
    @(negedge sys_clk);
    err_clr = 1'b0;
    if (rx_frame_err !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL ferr_clear: got %b, expected 0", rx_frame_err);
    end
    testsRun++;
  endtask

  task automatic test_overflow();
    logic [7:0] expByte;
    for (int i = 0; i <= 16; i++) begin
      sendFrame(8'(i), 1'b1, BIT);
      modelPush(8'(i));
    end
    driveBit(1'b1, 20);
    if (rx_count !== 5'(modelQ.size()) || rx_overflow !== modelOvf) begin
      testsFailed++;
      $display("[TB] FAIL ovf_state: got count=%0d ovf=%b, expected %0d/%b", rx_count, rx_overflow, modelQ.size(), modelOvf);
    end
    testsRun++;
    for (int i = 0; i < 16; i++) begin
      expByte = modelQ.pop_front();
      if (rx_valid !== 1'b1 || rx_data !== expByte) begin
        testsFailed++;
        $display("[TB] FAIL ovf_pop%0d: got valid=%b data=%h, expected 1/%h", i, rx_valid, rx_data, expByte);
      end
      testsRun++;
      popOnce();
    end
    if (rx_valid !== 1'b0 || rx_count !== 5'd0) begin
      testsFailed++;
      $display("[TB] FAIL ovf_empty: got valid=%b count=%0d, expected 0/0", rx_valid, rx_count);
    end
    testsRun++;
    err_clr = 1'b1;
    @(negedge sys_clk);
    err_clr = 1'b0;
    modelOvf = 1'b0;
    if (rx_overflow !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL ovf_clear: got %b, expected 0", rx_overflow);
    end
    testsRun++;
  endtask

  task automatic test_full_pop();
    logic [7:0] b;
    logic [7:0] expByte;
    logic       seen;
    int         bc;
    for (int i = 0; i < 16; i++) begin
      b  = 8'($urandom_range(0, 255));
      bc = int'($urandom_range(158, 162));
      sendFrame(b, 1'b1, bc);
      modelPush(b);
      driveBit(1'b1, int'($urandom_range(0, 30)));
    end
    driveBit(1'b1, 20);
    if (rx_count !== 5'd16 || rx_overflow !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL full_fill: got count=%0d ovf=%b, expected 16/0", rx_count, rx_overflow);
    end
    testsRun++;
    b = 8'h77;
    driveBit(1'b0, BIT);
    for (int i = 0; i < 8; i++) driveBit(b[i], BIT);
    RX   = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < BIT; k++) begin
      if (!seen && dut.push_q === 1'b1) begin
        seen    = 1'b1;
        expByte = modelQ.pop_front();
        if (rx_data !== expByte) begin
          testsFailed++;
          $display("[TB] FAIL full_pop_head: got %h, expected %h", rx_data, expByte);
        end
        testsRun++;
        modelQ.push_back(8'h77);
        rx_rd = 1'b1;
      end else begin
        rx_rd = 1'b0;
      end
      @(negedge sys_clk);
    end
    rx_rd = 1'b0;
    if (seen !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL full_pop_timeout: push of 77 not observed within %0d cycles", BIT);
    end
    testsRun++;
    if (rx_count !== 5'd16 || rx_overflow !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL full_pop_state: got count=%0d ovf=%b, expected 16/0", rx_count, rx_overflow);
    end
    testsRun++;
    while (modelQ.size() > 0) begin
      expByte = modelQ.pop_front();
      if (rx_valid !== 1'b1 || rx_data !== expByte) begin
        testsFailed++;
        $display("[TB] FAIL full_drain: got valid=%b data=%h, expected 1/%h", rx_valid, rx_data, expByte);
      end
      testsRun++;
      popOnce();
    end
    if (rx_count !== 5'd0) begin
      testsFailed++;
      $display("[TB] FAIL full_drain_empty: got count=%0d, expected 0", rx_count);
    end
    testsRun++;
  endtask

  task automatic test_reset_enable();
    logic [7:0] b;
    sendFrame(8'h42, 1'b1, BIT);
    sendFrame(8'hE7, 1'b0, BIT);
    driveBit(1'b1, 100);
    if (rx_valid !== 1'b1 || rx_frame_err !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL rst_pre: got valid=%b ferr=%b, expected 1/1", rx_valid, rx_frame_err);
    end
    testsRun++;
    b = 8'hF0;
    driveBit(1'b0, BIT);
    for (int i = 0; i < 4; i++) driveBit(b[i], BIT);
    driveBit(b[4], BIT / 2);
    sys_nrst = 1'b0;
    #1;
    if (rx_valid !== 1'b0 || rx_data !== 8'h00 || rx_count !== 5'd0 ||
        rx_overflow !== 1'b0 || rx_frame_err !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL rst_mid: got valid=%b data=%h count=%0d ovf=%b ferr=%b, expected all 0",
               rx_valid, rx_data, rx_count, rx_overflow, rx_frame_err);
    end
    testsRun++;
    modelQ.delete();
    modelOvf = 1'b0;
    RX = 1'b1;
    repeat (3) @(negedge sys_clk);
    sys_nrst = 1'b1;
    driveBit(1'b1, 50);
    sendFrame(8'hC3, 1'b1, BIT);
    modelPush(8'hC3);
    driveBit(1'b1, 20);
    if (rx_count !== 5'd1 || rx_data !== modelQ[0]) begin
      testsFailed++;
      $display("[TB] FAIL rst_after: got count=%0d data=%h, expected 1/%h", rx_count, rx_data, modelQ[0]);
    end
    testsRun++;
    popOnce();
    void'(modelQ.pop_front());
    rx_en = 1'b0;
    sendFrame(8'h99, 1'b1, BIT);
    driveBit(1'b1, 20);
    if (rx_valid !== 1'b0 || rx_count !== 5'd0) begin
      testsFailed++;
      $display("[TB] FAIL en_off: got valid=%b count=%0d, expected 0/0", rx_valid, rx_count);
    end
    testsRun++;
    rx_en = 1'b1;
  endtask

  // Run every scenario in order and report a single summary.
  initial begin
    testsRun    = 0;
    testsFailed = 0;
    modelOvf    = 1'b0;
    sys_nrst    = 1'b0;
    rx_en       = 1'b1;
    rx_rd       = 1'b0;
    err_clr     = 1'b0;
    RX          = 1'b1;
    @(negedge sys_clk);
    test_reset();
    test_basic();
    test_glitch_back_to_back();
    test_frame_err();
    test_overflow();
    test_full_pop();
    test_reset_enable();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/uart_rx_buffered.md
Name: uart_rx_buffered

Overview:
Receive-side counterpart of the buffered UART transmit path. Oversamples the asynchronous RX line and decodes 8N1 frames, using a 3-sample majority vote per bit. Good bytes are pushed into a show-ahead RX FIFO, which the user pops with a single-cycle read strobe. Sticky overflow and framing-error flags report lost data to the validation host.

Parameters:
CLK_HZ, 50_000_000, system clock frequency in Hz
BAUD, 38400, line baud rate
OVERSAMPLE, 16, sample ticks per bit; fixed at 16 and checked by elaboration assertion
DEPTH, 16, RX FIFO depth in bytes; power of 2, at least 2

Ports:
sys_clk  in  1  system clock; all state updates on the rising edge
sys_nrst  in  1  asynchronous active-low reset
rx_en  in  1  1: receiver may start new frames
rx_rd  in  1  pop strobe; honoured only when rx_valid=1
rx_valid  out  1  FIFO not empty
rx_data  out  8  FIFO head byte; 0 when empty
rx_count  out  $clog2(DEPTH)+1  FIFO occupancy
rx_overflow  out  1  sticky: a good byte arrived while the FIFO was full
rx_frame_err  out  1  sticky: stop bit sampled as 0
err_clr  in  1  clears both sticky flags
RX  in  1  asynchronous serial input; idle high

Behaviour:
- Reset values: rx_valid=0, rx_data=0, rx_count=0, rx_overflow=0, rx_frame_err=0, FSM=IDLE, FIFO pointers=0, RX synchroniser flops=1, tick counter=0. Reset mid-frame discards the partial byte.
- Synchroniser: 2 flops on RX; every reference to "line" below means the synchronised value.
- Tick generator:
  - DIV = round(CLK_HZ/(BAUD*16)), minimum 1.
  - Counter runs 0..DIV-1 and emits a 1-cycle tick at DIV-1.
  - Counter runs freely; it is not restarted on a start edge.
- Bit timing: per-bit sample counter sc counts 0..15 on ticks. Samples are taken at sc=7, 8, 9; the bit value is the majority of the three, decided at sc=9.
- FSM states:
  - IDLE: on a tick with line=0 and rx_en=1, set sc=0 and go to START.
  - START: at sc=9, majority 1 means a glitch: go to IDLE with no flag set. Majority 0 means a valid start: continue, and at sc=15 go to DATA with bit index 0.
  - DATA: shift the majority bit in LSB first at sc=9. At sc=15, advance the index; after index 7, go to STOP.
  - STOP: at sc=9, majority 1 pushes the byte and goes to IDLE immediately, which allows resync to the next start. Majority 0 sets rx_frame_err, drops the byte, and goes to BREAK.
  - BREAK: wait for a tick with line=1, then go to IDLE. A held-low line therefore never produces bytes.
- rx_en=0 during START/DATA/STOP aborts to IDLE on the next cycle; no push, no flag.
- Latency:
  - The push occurs in the cycle after the stop decision.
  - rx_valid, rx_count and rx_data update in the cycle after the push, i.e. registered occupancy.
- FIFO, show-ahead:
  - rx_data = mem[rd_ptr] when not empty.
  - A pop advances rd_ptr; the next head is visible in the following cycle.
  - Pop when empty is ignored.
  - Push when full and no pop: byte dropped, rx_overflow set, FIFO unchanged.
  - Push and pop in the same cycle when full: both succeed, rx_count stays DEPTH, no overflow.
  - Push and pop in the same cycle otherwise: rx_count unchanged.
  - Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- Flags: err_clr in the same cycle as a new error leaves the flag set (set wins). Flags do not affect reception.

Decomposition:
- Shared uart_pkg holds:
  - the rx_state_t enum {IDLE, START, DATA, STOP, BREAK};
  - localparams OVERSAMPLE=16, SAMPLE_LO=7, SAMPLE_HI=9;
  - the function calc_div(clk_hz, baud).
- One sub-module, uart_rx_sfifo: a parameterised synchronous show-ahead byte FIFO with push/pop/full/empty/count, reusable on the TX side.

Test Plan:
Common setup: CLK_HZ=6_144_000, BAUD=38400, so DIV=10 and 1 bit = 160 cycles; DEPTH=16.
- Basic byte: drive 0xA5 as 8N1 -> rx_valid=1 within 2 cycles after stop mid-bit, rx_data=0xA5, rx_count=1. Pulse rx_rd -> rx_valid=0, rx_data=0, rx_count=0.
- Glitch: drive RX low for 40 cycles, then high -> no push, FSM back in IDLE, rx_frame_err=0. Back-to-back bytes 0x00 then 0xFF, and a frame at BAUD+3% carrying 0x5A -> all three received exactly.
- Framing error: send 0x3C with stop=0, then hold low 400 cycles -> nothing pushed, rx_frame_err=1, FSM in BREAK. Line high, send 0x11 -> 0x11 received. err_clr -> rx_frame_err=0.
- Overflow: send 0x00..0x10 (17 bytes) with no reads -> rx_count=16, rx_overflow=1. 16 pops return 0x00..0x0F in order; 0x10 is lost.
- Full with simultaneous pop: FIFO full; pulse rx_rd in the exact push cycle of a new byte 0x77 -> rx_count stays 16, rx_overflow stays 0, 0x77 is last out.
- Reset and enable: assert sys_nrst during data bit 4 -> all outputs 0 immediately. Release, then send 0xC3 -> 0xC3 received. With rx_en=0, send 0x99 -> nothing pushed.
